// File: rtl/excp_ctrl.sv
// Exception/interrupt sequencer: arbitrates commit-stage events, strobes CP0, flushes, then redirects fetch.
// Optional build macro EXCP_CTRL_PERF_EN adds perf_exc_cnt / perf_int_cnt event counters.
module excp_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_is_slot,
  input  logic [6:0]  m_excp,
  input  logic [31:0] m_vaddr,
  input  logic        m_is_eret,
  input  logic        cp0_int_pending,
  input  logic [31:0] cp0_epc,
  output logic [6:0]  cp0_etype,
  output logic        cp0_exc,
  output logic        cp0_inter_valid,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_int_pc,
  output logic        cp0_is_slot,
  output logic [31:0] cp0_vaddr,
  output logic        cp0_is_eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
`ifdef EXCP_CTRL_PERF_EN
  ,
  output logic [31:0] perf_exc_cnt,
  output logic [31:0] perf_int_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam int             CW       = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FLUSH_CYCLES - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   target, target_next;
  logic          idle_commit, take_int, take_exc, take_eret;

  // Gating with resetn keeps every output at zero while reset is held.
  assign idle_commit = resetn && (state == IDLE) && m_valid;
  assign take_int    = idle_commit && cp0_int_pending;
  assign take_exc    = idle_commit && !cp0_int_pending && (m_excp != 7'd0);
  assign take_eret   = idle_commit && !cp0_int_pending && (m_excp == 7'd0) && m_is_eret;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      target <= target_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    target_next     = target;
    cp0_etype       = 7'd0;
    cp0_exc         = 1'b0;
    cp0_inter_valid = 1'b0;
    cp0_pc          = 32'd0;
    cp0_int_pc      = 32'd0;
    cp0_is_slot     = 1'b0;
    cp0_vaddr       = 32'd0;
    cp0_is_eret     = 1'b0;
    flush           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (take_int) begin
          cp0_inter_valid = 1'b1;
          cp0_is_slot     = m_is_slot;
          cp0_int_pc      = m_is_slot ? (m_pc - 32'd4) : m_pc;
          target_next     = EXC_VECTOR;
          state_next      = FLUSH;
        end else if (take_exc) begin
          cp0_exc     = 1'b1;
          cp0_etype   = m_excp;
          cp0_pc      = m_pc;
          cp0_vaddr   = m_vaddr;
          cp0_is_slot = m_is_slot;
          target_next = EXC_VECTOR;
          state_next  = FLUSH;
        end else if (take_eret) begin
          cp0_is_eret = 1'b1;
          target_next = cp0_epc;
          state_next  = FLUSH;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        // Saturating count so a stalled FSM can never alias back to zero.
        if (cnt == CNT_LAST) begin
          state_next = REDIRECT;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        if (redirect_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef EXCP_CTRL_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_exc_cnt <= 32'd0;
      perf_int_cnt <= 32'd0;
    end else begin
      if (cp0_exc)         perf_exc_cnt <= perf_exc_cnt + 32'd1;
      if (cp0_inter_valid) perf_int_cnt <= perf_int_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed self-checking bench for excp_ctrl: exceptions, interrupts, ERET, back-pressure and reset abort.
module tb_excp_ctrl;

  logic        clk;
  logic        resetn;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_is_slot;
  logic [6:0]  m_excp;
  logic [31:0] m_vaddr;
  logic        m_is_eret;
  logic        cp0_int_pending;
  logic [31:0] cp0_epc;
  logic [6:0]  cp0_etype;
  logic        cp0_exc;
  logic        cp0_inter_valid;
  logic [31:0] cp0_pc;
  logic [31:0] cp0_int_pc;
  logic        cp0_is_slot;
  logic [31:0] cp0_vaddr;
  logic        cp0_is_eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
`ifdef EXCP_CTRL_PERF_EN
  logic [31:0] perf_exc_cnt;
  logic [31:0] perf_int_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  excp_ctrl dut (
    .clk             (clk),
    .resetn          (resetn),
    .m_valid         (m_valid),
    .m_pc            (m_pc),
    .m_is_slot       (m_is_slot),
    .m_excp          (m_excp),
    .m_vaddr         (m_vaddr),
    .m_is_eret       (m_is_eret),
    .cp0_int_pending (cp0_int_pending),
    .cp0_epc         (cp0_epc),
    .cp0_etype       (cp0_etype),
    .cp0_exc         (cp0_exc),
    .cp0_inter_valid (cp0_inter_valid),
    .cp0_pc          (cp0_pc),
    .cp0_int_pc      (cp0_int_pc),
    .cp0_is_slot     (cp0_is_slot),
    .cp0_vaddr       (cp0_vaddr),
    .cp0_is_eret     (cp0_is_eret),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_ready  (redirect_ready)
`ifdef EXCP_CTRL_PERF_EN
    ,
    .perf_exc_cnt    (perf_exc_cnt),
    .perf_int_cnt    (perf_int_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m_valid = 0; m_pc = 0; m_is_slot = 0; m_excp = 0; m_vaddr = 0;
    m_is_eret = 0; cp0_int_pending = 0;
  endtask

  // Accept the pending redirect (bounded wait) and confirm the pipeline is released.
  task automatic finish_event(input string tag, input logic [31:0] exp_pc);
    int n;
    n = 0;
    redirect_ready = 1;
    while (!redirect_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_rv_seen"}, {31'd0, redirect_valid}, 32'd1);
    chk({tag, "_rpc"}, redirect_pc, exp_pc);
    step();
    redirect_ready = 0;
    chk({tag, "_rv_drop"}, {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_flush_drop"}, {31'd0, flush}, 32'd0);
    $display("txn %s: redirect to %h accepted", tag, exp_pc);
  endtask

  initial begin
    resetn = 0; redirect_ready = 0; cp0_epc = 0;
    clear_inputs();
    // Inputs that would trigger an exception must be ignored while reset is held.
    m_valid = 1; m_excp = 7'b0010000; m_pc = 32'h1234_5678;
    #12;
    chk("rst_exc", {31'd0, cp0_exc}, 32'd0);
    chk("rst_etype", {25'd0, cp0_etype}, 32'd0);
    chk("rst_pc", cp0_pc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    $display("txn reset: outputs idle");
    clear_inputs();
    resetn = 1;
    step();

    // Syscall, not in a slot; full latency check.
    m_valid = 1; m_pc = 32'hBFC0_0100; m_excp = 7'b0010000; m_vaddr = 32'h0000_0040;
    @(negedge clk);
    chk("sys_exc", {31'd0, cp0_exc}, 32'd1);
    chk("sys_etype", {25'd0, cp0_etype}, 32'h10);
    chk("sys_pc", cp0_pc, 32'hBFC0_0100);
    chk("sys_vaddr", cp0_vaddr, 32'h0000_0040);
    chk("sys_int", {31'd0, cp0_inter_valid}, 32'd0);
    chk("sys_flush0", {31'd0, flush}, 32'd0);
    step();
    clear_inputs();
    chk("sys_exc_once", {31'd0, cp0_exc}, 32'd0);
    chk("sys_flush1", {31'd0, flush}, 32'd1);
    chk("sys_rv1", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("sys_flush2", {31'd0, flush}, 32'd1);
    chk("sys_rv2", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("sys_rv3", {31'd0, redirect_valid}, 32'd1);
    chk("sys_flush3", {31'd0, flush}, 32'd1);
    finish_event("syscall", 32'hBFC0_0380);
`ifdef EXCP_CTRL_PERF_EN
    chk("perf_exc", perf_exc_cnt, 32'd1);
    chk("perf_int0", perf_int_cnt, 32'd0);
`endif

    // Interrupt on a delay-slot instruction.
    m_valid = 1; m_pc = 32'h8000_0008; m_is_slot = 1; cp0_int_pending = 1;
    @(negedge clk);
    chk("int_valid", {31'd0, cp0_inter_valid}, 32'd1);
    chk("int_pc", cp0_int_pc, 32'h8000_0004);
    chk("int_slot", {31'd0, cp0_is_slot}, 32'd1);
    chk("int_exc", {31'd0, cp0_exc}, 32'd0);
    step();
    clear_inputs();
    finish_event("int_slot", 32'hBFC0_0380);

    // Interrupt beats a simultaneous overflow.
    m_valid = 1; m_pc = 32'h8000_0020; m_excp = 7'b0000100; cp0_int_pending = 1;
    @(negedge clk);
    chk("ovf_int_valid", {31'd0, cp0_inter_valid}, 32'd1);
    chk("ovf_int_exc", {31'd0, cp0_exc}, 32'd0);
    chk("ovf_int_etype", {25'd0, cp0_etype}, 32'd0);
    chk("ovf_int_pc", cp0_int_pc, 32'h8000_0020);
    step();
    clear_inputs();
    finish_event("int_ovf", 32'hBFC0_0380);

    // ERET with held-off redirect; commit inputs held active during flush must be ignored.
    m_valid = 1; m_pc = 32'h8000_0300; m_is_eret = 1; cp0_epc = 32'h8000_1234;
    @(negedge clk);
    chk("eret_strobe", {31'd0, cp0_is_eret}, 32'd1);
    chk("eret_exc", {31'd0, cp0_exc}, 32'd0);
    step();
    cp0_epc = 32'hDEAD_BEEF;
    chk("eret_once", {31'd0, cp0_is_eret}, 32'd0);
    step();
    step();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      chk("eret_rv_hold", {31'd0, redirect_valid}, 32'd1);
      chk("eret_rpc_hold", redirect_pc, 32'h8000_1234);
      step();
    end
    $display("txn eret: redirect held 5 cycles without ready");
    finish_event("eret", 32'h8000_1234);

    // Pending interrupt waits for a valid commit.
    cp0_int_pending = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("intwait_none", {31'd0, cp0_inter_valid}, 32'd0);
      step();
    end
    m_valid = 1; m_pc = 32'h8000_0100;
    @(negedge clk);
    chk("intwait_fire", {31'd0, cp0_inter_valid}, 32'd1);
    chk("intwait_pc", cp0_int_pc, 32'h8000_0100);
    chk("intwait_slot", {31'd0, cp0_is_slot}, 32'd0);
    step();
    clear_inputs();
    finish_event("int_wait", 32'hBFC0_0380);

    // Reset during flush aborts the sequence without a redirect.
    m_valid = 1; m_pc = 32'hBFC0_0200; m_excp = 7'b0010000;
    @(negedge clk);
    chk("abort_exc", {31'd0, cp0_exc}, 32'd1);
    step();
    clear_inputs();
    chk("abort_flush_pre", {31'd0, flush}, 32'd1);
    resetn = 0;
    #1;
    chk("abort_flush", {31'd0, flush}, 32'd0);
    chk("abort_rv", {31'd0, redirect_valid}, 32'd0);
`ifdef EXCP_CTRL_PERF_EN
    chk("abort_perf", perf_exc_cnt, 32'd0);
`endif
    step();
    resetn = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_rv", {31'd0, redirect_valid}, 32'd0);
      chk("abort_no_flush", {31'd0, flush}, 32'd0);
    end
    $display("txn reset_abort: no redirect issued");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/excp_ctrl.md
Name: excp_ctrl

Overview:
Pipeline-side exception and interrupt sequencer that drives the CP0 exception/commit interface. It samples the commit (M2) stage, arbitrates synchronous exceptions, pending interrupts and ERET, and presents one exception record per event to CP0. It then flushes the pipeline and issues a fetch redirect to the exception vector or to EPC. It sits between the memory-commit stage, CP0 and the fetch unit.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, PC loaded on exception or interrupt (EXL=0 or 1, BEV ignored)
FLUSH_CYCLES, 2, cycles flush stays high before the redirect is offered (≥1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
m_valid  in  1  commit-stage instruction present
m_pc  in  32  commit-stage PC
m_is_slot  in  1  commit instruction is in a branch delay slot
m_excp  in  7  {adesD,adelD,syscall,trap,overflow,reserveInstr,badVaddrF}
m_vaddr  in  32  data address of load/store
m_is_eret  in  1  commit instruction is ERET
cp0_int_pending  in  1  CP0 interrupt condition (IE & ~EXL & masked IP)
cp0_epc  in  32  current EPC
cp0_etype  out  7  exception flags to CP0
cp0_exc  out  1  synchronous exception strobe (ctype==EXCEPTION)
cp0_inter_valid  out  1  interrupt-accept strobe
cp0_pc  out  32  PC of excepting instruction
cp0_int_pc  out  32  restart PC for interrupt
cp0_is_slot  out  1  delay-slot flag
cp0_vaddr  out  32  bad data address
cp0_is_eret  out  1  ERET strobe
flush  out  1  kill all younger pipeline state
redirect_valid  out  1  fetch redirect offered
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (resetn=0, async): state IDLE; all outputs 0; captured registers 0.
- States: IDLE, FLUSH, REDIRECT.
- IDLE, each cycle with m_valid=1, priority: interrupt > exception (m_excp!=0) > ERET > normal commit.
- Interrupt (cp0_int_pending=1 && m_valid): the instruction does not commit. Same cycle: cp0_inter_valid=1, cp0_is_slot=m_is_slot, cp0_int_pc = m_is_slot ? m_pc-4 : m_pc (32-bit wrap), cp0_etype=0, target=EXC_VECTOR. Go to FLUSH.
- Exception: same cycle: cp0_exc=1, cp0_etype=m_excp, cp0_pc=m_pc, cp0_vaddr=m_vaddr, cp0_is_slot=m_is_slot. Target=EXC_VECTOR. Go to FLUSH.
- ERET (no exception): cp0_is_eret=1 for one cycle; target=cp0_epc sampled that cycle. Go to FLUSH.
- cp0_int_pending with m_valid=0: no action; the interrupt waits for the next valid commit.
- Strobes (cp0_exc, cp0_inter_valid, cp0_is_eret) are combinational from IDLE inputs and last exactly one cycle per event. At most one strobe is high in any cycle.
- FLUSH: flush=1 for FLUSH_CYCLES cycles, counted from the cycle after the strobe. Commit inputs are ignored. The flush counter saturates and does not wrap. Then go to REDIRECT.
- REDIRECT: flush=1, redirect_valid=1, redirect_pc=target held stable. On redirect_ready=1 go to IDLE; flush and redirect_valid drop the next cycle. redirect_valid never drops without ready.
- Event latency: strobe at T; flush at T+1..T+FLUSH_CYCLES; redirect_valid from T+FLUSH_CYCLES+1.
- Reset mid-sequence aborts to IDLE with no redirect issued.

Optional Feature:
EXCP_CTRL_PERF_EN: when defined, adds output ports perf_exc_cnt[31:0] and perf_int_cnt[31:0]. These increment on each cp0_exc and each cp0_inter_valid strobe respectively, wrap at 2^32, and reset to 0. When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Syscall at m_pc=0xBFC0_0100, not a slot -> cp0_exc=1, cp0_etype=7'b0010000, cp0_pc=0xBFC0_0100 for one cycle; flush for 2 cycles; redirect_pc=0xBFC0_0380.
- Interrupt at slot instruction m_pc=0x8000_0008 -> cp0_inter_valid=1, cp0_int_pc=0x8000_0004, cp0_is_slot=1, cp0_exc=0.
- cp0_int_pending=1 together with overflow on the same instruction -> only cp0_inter_valid fires; cp0_etype=0.
- ERET with cp0_epc=0x8000_1234 -> cp0_is_eret pulses once; redirect_pc=0x8000_1234. With redirect_ready held low for 5 cycles, redirect_valid stays high throughout.
- Pending interrupt while m_valid=0 for 3 cycles -> no strobe; strobe on the first m_valid=1 cycle.
- resetn pulsed low during FLUSH -> outputs go to 0 immediately and redirect_valid never asserts. With EXCP_CTRL_PERF_EN defined, perf_exc_cnt=1 after the syscall scenario.
